// File: rtl/ide_host_pio.sv
// Host-side ATA PIO engine: one register read/write per request, timed strobes,
// optional status poll that re-reads until BSY (bit 7) clears or the retry budget runs out.
module ide_host_pio #(
  parameter int T_SETUP    = 2,
  parameter int T_ACTIVE   = 6,
  parameter int T_HOLD     = 1,
  parameter int T_RECOVER  = 4,
  parameter int POLL_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        poll,
  input  logic [4:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err,
  input  logic [15:0] ide_data_in,
  output logic [15:0] ide_data_out,
  output logic        ide_data_oe,
  output logic        ide_dior,
  output logic        ide_diow,
  output logic [1:0]  ide_cs,
  output logic [2:0]  ide_da
);

  typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, HOLD, RECOVER, DONE} state_t;

  typedef struct packed {
    logic       we;
    logic       poll;
    logic [4:0] addr;
  } pio_req_t;

  // Down-counter reload: a phase lasts cnt+1 clocks, and 0 is stretched to 1.
  function automatic logic [7:0] tcnt(input int p);
    return (p < 1) ? 8'd0 : 8'(p - 1);
  endfunction

  localparam logic [7:0]  C_SETUP   = tcnt(T_SETUP);
  localparam logic [7:0]  C_ACTIVE  = tcnt(T_ACTIVE);
  localparam logic [7:0]  C_HOLD    = tcnt(T_HOLD);
  localparam logic [7:0]  C_RECOVER = tcnt(T_RECOVER);
  localparam logic [15:0] POLL_MAX  = 16'((POLL_LIMIT < 1) ? 1 : POLL_LIMIT);

  state_t     state;
  logic [7:0] cnt;
  pio_req_t   cur;
  logic [15:0] rd_cnt;
  logic       again;
  logic       err_pend;
  logic       accept;

  // DONE also accepts so a held req chains back-to-back without an IDLE bubble.
  assign accept = req && (state == IDLE || state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      cur          <= '0;
      rd_cnt       <= '0;
      again        <= 1'b0;
      err_pend     <= 1'b0;
      rdata        <= '0;
      ack          <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      ide_data_out <= '0;
      ide_data_oe  <= 1'b0;
      ide_dior     <= 1'b1;
      ide_diow     <= 1'b1;
      ide_cs       <= 2'b11;
      ide_da       <= 3'b000;
    end else begin
      ack <= 1'b0;
      unique case (state)
        IDLE: ;
        SETUP:
          if (cnt == 8'd0) begin
            state <= ACTIVE;
            cnt   <= C_ACTIVE;
            if (cur.we) ide_diow <= 1'b0;
            else        ide_dior <= 1'b0;
          end else cnt <= cnt - 8'd1;
        ACTIVE:
          if (cnt == 8'd0) begin
            state    <= HOLD;
            cnt      <= C_HOLD;
            ide_dior <= 1'b1;
            ide_diow <= 1'b1;
            // Sampled on the edge that releases dior, while the device still drives.
            if (!cur.we) begin
              rdata  <= ide_data_in;
              rd_cnt <= rd_cnt + 16'd1;
            end
          end else cnt <= cnt - 8'd1;
        HOLD:
          if (cnt == 8'd0) begin
            state        <= RECOVER;
            cnt          <= C_RECOVER;
            ide_cs       <= 2'b11;
            ide_da       <= 3'b000;
            ide_data_oe  <= 1'b0;
            ide_data_out <= '0;
            again        <= cur.poll && rdata[7] && (rd_cnt <  POLL_MAX);
            err_pend     <= cur.poll && rdata[7] && (rd_cnt >= POLL_MAX);
          end else cnt <= cnt - 8'd1;
        RECOVER:
          if (cnt == 8'd0) begin
            if (again) begin
              state  <= SETUP;
              cnt    <= C_SETUP;
              ide_cs <= cur.addr[4:3];
              ide_da <= cur.addr[2:0];
            end else begin
              state <= DONE;
              ack   <= 1'b1;
              err   <= err_pend;
            end
          end else cnt <= cnt - 8'd1;
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        cur          <= '{we: we, poll: poll & ~we, addr: addr};
        state        <= SETUP;
        cnt          <= C_SETUP;
        busy         <= 1'b1;
        err          <= 1'b0;
        rd_cnt       <= '0;
        again        <= 1'b0;
        err_pend     <= 1'b0;
        ide_cs       <= addr[4:3];
        ide_da       <= addr[2:0];
        ide_data_oe  <= we;
        ide_data_out <= we ? wdata : 16'h0000;
      end
    end
  end

endmodule

// File: doc/ide_host_pio.md
Name: ide_host_pio

Overview:
- Host-side (initiator) ATA PIO bus engine. Turns single-register requests from the disk controller FSM into timed IDE register read/write cycles on ide_dior/ide_diow/ide_cs/ide_da/data.
- Provides an optional status-poll mode: it repeatedly reads a register until BSY clears, with a bounded retry count.
- It is the host end of the bus the simulation disk model responds to.

Parameters:
- T_SETUP, 2, clocks with address/cs valid before strobe asserts (1..255)
- T_ACTIVE, 6, clocks strobe held low (1..255)
- T_HOLD, 1, clocks address/data held after strobe deasserts (1..255)
- T_RECOVER, 4, clocks cs deasserted before next cycle or ack (1..255)
- POLL_LIMIT, 1024, maximum status reads per poll request (1..65535)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req  in  1  request strobe, sampled only when busy=0
- we  in  1  1=register write, 0=register read
- poll  in  1  read request repeats until data[7]=0
- addr  in  5  {cs[1:0],da[2:0]}; 0x10 data, 0x12-0x16 taskfile, 0x17 status/command, 0x0e devctrl
- wdata  in  16  write data
- rdata  out  16  captured read data
- ack  out  1  one-clock completion pulse
- busy  out  1  transaction in progress
- err  out  1  poll limit exhausted
- ide_data_in  in  16  device data bus
- ide_data_out  out  16  host data bus
- ide_data_oe  out  1  host drives data bus
- ide_dior  out  1  read strobe, active low
- ide_diow  out  1  write strobe, active low
- ide_cs  out  2  chip selects (idle 2'b11)
- ide_da  out  3  register address (idle 3'b000)

Behaviour:
- Reset values: rdata=0, ack=0, busy=0, err=0, ide_dior=1, ide_diow=1, ide_cs=2'b11, ide_da=0, ide_data_out=0, ide_data_oe=0, state IDLE.
- Reset mid-transaction: at the next edge all outputs take their reset values. No ack is issued.
- FSM states: IDLE -> SETUP -> ACTIVE -> HOLD -> RECOVER -> DONE -> IDLE.
  - Each timed state lasts exactly its parameter count, using an 8-bit down-counter.
  - A parameter of 0 behaves as 1.
- IDLE: busy=0. On req=1, latch addr, we, wdata and (poll & ~we), clear err, enter SETUP. poll with we=1 is treated as a plain write.
- SETUP: ide_cs/ide_da = latched addr; both strobes high.
  - Write: ide_data_oe=1 and ide_data_out=wdata, held from SETUP through HOLD.
- ACTIVE: ide_diow=0 (write) or ide_dior=0 (read). cs/da stable.
  - Read: rdata is loaded from ide_data_in on the edge that ends ACTIVE. That is the same edge that returns dior high, so the sample is taken before the device clears its bus.
- HOLD: strobes high; cs/da and write data still driven.
- RECOVER: ide_cs=2'b11, ide_da=0, ide_data_oe=0, ide_data_out=0.
- Poll decision, made at the end of HOLD:
  - Captured bit 7 = 1 and reads issued < POLL_LIMIT: after RECOVER, return to SETUP. No ack.
  - Captured bit 7 = 0: proceed to DONE with err=0.
  - Bit 7 = 1 and reads issued = POLL_LIMIT: proceed to DONE with err=1.
  - Read counter is 16 bits, cleared on accept.
- DONE: ack=1 for exactly one clock, then IDLE. rdata holds the last captured value.
- busy=1 from the clock after the accepting edge through the DONE clock inclusive. req is ignored while busy.
  - req held continuously high: the next request is accepted on the edge that leaves DONE.
- Latency for a non-poll request: ack is high in clock T_SETUP+T_ACTIVE+T_HOLD+T_RECOVER+1 after the accepting edge (14 with defaults).
  - A poll taking k reads: ack at k*(T_SETUP+T_ACTIVE+T_HOLD+T_RECOVER)+1.
- Strobe exclusivity: ide_dior and ide_diow are never both 0. No strobe is asserted while ide_cs=2'b11.
- err holds its value until the next accepted request. rdata holds until the next read capture. Writes do not alter rdata.

Test Plan:
- Reset for 3 clocks -> all outputs at reset values; busy=0; cs=2'b11.
- Write addr 0x12, wdata 0x0001 -> cs=2'b10, da=3'b010 for 9 clocks; diow=0 for exactly 6 clocks; data_oe=1 from SETUP through HOLD with data 0x0001; single ack 14 clocks after accept; device model shows seccnt=1.
- Write 0x17 = 0x0020, then read addr 0x10 with model returning 0x414c -> dior low 6 clocks, rdata=0x414c on ack, diow stays 1, data_oe stays 0.
- Poll read 0x17 with device reporting 0x00d0 for 3 reads then 0x0050 -> exactly 4 dior pulses, each separated by 4 recovery clocks with cs=11; single ack at clock 53; rdata=0x0050; err=0.
- POLL_LIMIT=4, BSY stuck (0x00d0) -> exactly 4 reads, ack with err=1, rdata=0x00d0; the next request clears err.
- Reset asserted during ACTIVE of a write -> next clock diow=1, data_oe=0, cs=11, no ack. A read issued after reset completes normally.
- req held high across two reads -> second SETUP begins the clock after ack; ack pulses are exactly 14 clocks apart.
